// File: rtl/bip_datapath.sv
// BIP execution datapath: 16-bit accumulator, add/sub ALU, data RAM and status flags.
// Control word and operand arrive combinationally each cycle. State updates on the
// rising clk edge that closes that cycle.
module bip_datapath #(
    parameter int DATA_W     = 16,
    parameter int OPERAND_W  = 11,
    parameter int RAM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] operand,
    input  logic [OPERAND_W-1:0] data_address,
    input  logic [1:0]           SelA,
    input  logic                 SelB,
    input  logic                 WrAcc,
    input  logic                 Op,
    input  logic                 WrRam,
    input  logic                 RdRam,
    output logic [DATA_W-1:0]    acc,
    output logic [DATA_W-1:0]    ram_rdata,
    output logic                 zero,
    output logic                 neg,
    output logic                 ovf
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

    // Accumulator source encodings
    localparam logic [1:0] SEL_RAM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    logic [DATA_W-1:0]     mem [RAM_DEPTH];
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     b_operand;
    logic [DATA_W-1:0]     alu_sum;
    logic [DATA_W-1:0]     alu_diff;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_ovf;
    logic [DATA_W-1:0]     acc_reg;
    logic [DATA_W-1:0]     acc_next;
    logic                  ovf_reg;
    logic                  ovf_next;

    // Upper address bits wrap away; fold them into an otherwise unused net.
    generate
        if (OPERAND_W > RAM_ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^data_address[OPERAND_W-1:RAM_ADDR_W];
        end
    endgenerate

    assign ram_addr = data_address[RAM_ADDR_W-1:0];
    assign imm      = {{(DATA_W-OPERAND_W){operand[OPERAND_W-1]}}, operand};

    // Combinational RAM read, gated to zero when no read is requested.
    always_comb begin
        ram_rdata = '0;
        if (RdRam) begin
            ram_rdata = mem[ram_addr];
        end
    end

    // ALU: add or subtract the selected B operand, with signed-overflow detection.
    always_comb begin
        b_operand  = SelB ? imm : ram_rdata;
        alu_sum    = acc_reg + b_operand;
        alu_diff   = acc_reg - b_operand;
        alu_result = Op ? alu_diff : alu_sum;
        if (Op) begin
            alu_ovf = (acc_reg[DATA_W-1] != b_operand[DATA_W-1]) &&
                      (alu_diff[DATA_W-1] != acc_reg[DATA_W-1]);
        end else begin
            alu_ovf = (acc_reg[DATA_W-1] == b_operand[DATA_W-1]) &&
                      (alu_sum[DATA_W-1] != acc_reg[DATA_W-1]);
        end
    end

    // Next accumulator value and sticky overflow; SelA=11 is a no-op write.
    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (WrAcc) begin
            case (SelA)
                SEL_RAM: acc_next = ram_rdata;
                SEL_IMM: acc_next = imm;
                SEL_ALU: begin
                    acc_next = alu_result;
                    ovf_next = ovf_reg | alu_ovf;
                end
                default: acc_next = acc_reg;
            endcase
        end
    end

    // Accumulator and overflow registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
        end
    end

    // RAM write of the pre-edge accumulator; suppressed while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (rst && WrRam) begin
            mem[ram_addr] <= acc_reg;
        end
    end

    assign acc  = acc_reg;
    assign ovf  = ovf_reg;
    assign zero = (acc_reg == '0);
    assign neg  = acc_reg[DATA_W-1];

endmodule

// File: tb/tb_bip_datapath.sv
// Testbench for bip_datapath: directed scenarios followed by random control words,
// all checked against an arithmetic reference model of the accumulator machine.
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] operand = '0;
    logic [10:0] data_address = '0;
    logic [1:0]  SelA = '0;
    logic        SelB = 1'b0;
    logic        WrAcc = 1'b0;
    logic        Op = 1'b0;
    logic        WrRam = 1'b0;
    logic        RdRam = 1'b0;
    logic [15:0] acc;
    logic [15:0] ram_rdata;
    logic        zero;
    logic        neg;
    logic        ovf;

    int          total = 0;
    int          bad = 0;

    // Reference model state (accumulator as unsigned 0..65535)
    int          m_acc = 0;
    int          m_ovf = 0;
    int          m_mem [1024];
    bit          m_valid [1024];
    logic [15:0] last_rdata;

    bip_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .operand      (operand),
        .data_address (data_address),
        .SelA         (SelA),
        .SelB         (SelB),
        .WrAcc        (WrAcc),
        .Op           (Op),
        .WrRam        (WrRam),
        .RdRam        (RdRam),
        .acc          (acc),
        .ram_rdata    (ram_rdata),
        .zero         (zero),
        .neg          (neg),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ":acc"},  32'(acc),  32'(m_acc));
        chk({tag, ":zero"}, 32'(zero), (m_acc == 0) ? 32'd1 : 32'd0);
        chk({tag, ":neg"},  32'(neg),  (m_acc >= 32768) ? 32'd1 : 32'd0);
        chk({tag, ":ovf"},  32'(ovf),  32'(m_ovf));
    endtask

    // One instruction cycle: drive, check read data mid-cycle, clock, check state.
    task automatic cyc(input int sa, input int sb, input int wa, input int op,
                       input int wr, input int rd, input int opd, input int addr);
        int a;
        int rexp;
        int imm;
        int b;
        int r;
        int nacc;
        SelA         = 2'(sa);
        SelB         = 1'(sb);
        WrAcc        = 1'(wa);
        Op           = 1'(op);
        WrRam        = 1'(wr);
        RdRam        = 1'(rd);
        operand      = 11'(opd);
        data_address = 11'(addr);
        #2;
        a    = addr % 1024;
        rexp = (rd != 0) ? m_mem[a] : 0;
        chk("rdata", 32'(ram_rdata), 32'(rexp));
        last_rdata = ram_rdata;
        imm  = (opd >= 1024) ? opd - 2048 : opd;
        b    = (sb != 0) ? imm : sx16(rexp);
        r    = (op != 0) ? sx16(m_acc) - b : sx16(m_acc) + b;
        nacc = m_acc;
        if (wa != 0) begin
            case (sa)
                0: nacc = rexp;
                1: nacc = imm & 32'h0000FFFF;
                2: begin
                    nacc = r & 32'h0000FFFF;
                    if (r > 32767 || r < -32768) m_ovf = 1;
                end
                default: nacc = m_acc;
            endcase
        end
        if (wr != 0) begin
            m_mem[a]   = m_acc;
            m_valid[a] = 1'b1;
        end
        m_acc = nacc;
        @(posedge clk);
        #1;
        WrAcc = 1'b0;
        WrRam = 1'b0;
        RdRam = 1'b0;
        check_state("cyc");
    endtask

    task automatic ld(input int v);
        cyc(1, 0, 1, 0, 0, 0, v, 0);
    endtask

    task automatic st(input int a);
        cyc(0, 0, 0, 0, 1, 0, 0, a);
    endtask

    // Double the accumulator through RAM scratch address a.
    task automatic dbl(input int a);
        st(a);
        cyc(2, 0, 1, 0, 0, 1, 0, a);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check_state("reset");
        chk("reset:zero1", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Load immediate 0x7FF sign-extends to 0xFFFF, then store and read back
        ld(11'h7FF);
        chk("ldimm:acc", 32'(acc), 32'h0000FFFF);
        chk("ldimm:neg", 32'(neg), 32'd1);
        st(5);
        cyc(3, 0, 0, 0, 0, 1, 0, 5);
        chk("rd5", 32'(last_rdata), 32'h0000FFFF);

        // Add/sub with RAM operand
        ld(16'h0010);
        st(3);
        ld(5);
        cyc(2, 0, 1, 0, 0, 1, 0, 3);
        chk("add_ram", 32'(acc), 32'h00000015);
        ld(5);
        cyc(2, 0, 1, 1, 0, 1, 0, 3);
        chk("sub_ram", 32'(acc), 32'h0000FFF5);
        chk("sub_ram:neg", 32'(neg), 32'd1);

        // Build 0x7FFF without overflow, then add 1 to overflow
        ld(11'h3FF);
        for (int i = 0; i < 5; i++) dbl(7);
        cyc(2, 1, 1, 0, 0, 0, 11'h01F, 0);
        chk("build7fff", 32'(acc), 32'h00007FFF);
        chk("pre_ovf", 32'(ovf), 32'd0);
        cyc(2, 1, 1, 0, 0, 0, 1, 0);
        chk("ovf:acc", 32'(acc), 32'h00008000);
        chk("ovf:set", 32'(ovf), 32'd1);
        ld(1);
        cyc(2, 1, 1, 0, 0, 0, 1, 0);
        cyc(2, 1, 1, 1, 0, 0, 1, 0);
        chk("ovf:sticky", 32'(ovf), 32'd1);

        // Simultaneous write/read with address wrap, then SelA=11 no-op
        ld(1);
        st(2);
        ld(16'h00AA);
        cyc(3, 0, 0, 0, 1, 1, 0, 11'h402);
        chk("wr_rd_old", 32'(last_rdata), 32'h00000001);
        cyc(3, 0, 0, 0, 0, 1, 0, 2);
        chk("wr_rd_new", 32'(last_rdata), 32'h000000AA);
        cyc(3, 1, 1, 0, 0, 0, 11'h155, 0);
        chk("sela11", 32'(acc), 32'h000000AA);

        // Build 0x1234, store it, then reset mid-run
        ld(11'h123);
        for (int i = 0; i < 4; i++) dbl(7);
        cyc(2, 1, 1, 0, 0, 0, 4, 0);
        st(9);
        chk("pre_rst:acc", 32'(acc), 32'h00001234);
        chk("pre_rst:ovf", 32'(ovf), 32'd1);
        #2 rst = 1'b0;
        #1;
        m_acc = 0;
        m_ovf = 0;
        check_state("midrst");
        // A write attempted across an edge while reset is held must not land
        WrRam        = 1'b1;
        data_address = 11'd9;
        @(posedge clk);
        #1;
        WrRam = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(3, 0, 0, 0, 0, 1, 0, 9);
        chk("rst_wr_suppr", 32'(last_rdata), 32'h00001234);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            int addr;
            int rd;
            addr = int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(0, 15));
            rd   = int'($urandom_range(0, 1));
            if (!m_valid[addr % 1024]) rd = 0;
            cyc(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), rd, int'($urandom_range(0, 2047)), addr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
